// File: rtl/bp_tracker_pkg.sv
// Shared types and constants for the branch resolve tracker.
package bp_tracker_pkg;

  // Width of PCs and targets carried in the entry/update structs.
  localparam int BP_ADDR_W = 32;

  // Fall-through distance used for not-taken redirects and training targets.
  localparam logic [BP_ADDR_W-1:0] PC_INCR = BP_ADDR_W'(4);

  // One in-flight prediction, captured at fetch.
  typedef struct packed {
    logic [BP_ADDR_W-1:0] pc;
    logic                 pred_taken;
    logic [BP_ADDR_W-1:0] pred_target;
  } bp_entry_t;

  // One predictor training write.
  typedef struct packed {
    logic [BP_ADDR_W-1:0] pc;
    logic                 taken;
    logic [BP_ADDR_W-1:0] target;
  } bp_update_t;

  // Training-write handshake state.
  typedef enum logic {
    UPD_IDLE,
    UPD_WAIT_ACK
  } upd_state_t;

endpackage

// File: rtl/bp_track_fifo.sv
// In-order queue of in-flight predictions with a head read port and a clear.
module bp_track_fifo
  import bp_tracker_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      push,
  input  bp_entry_t push_entry,
  input  logic      pop,
  input  logic      clear,
  output logic      full,
  output logic      empty,
  output bp_entry_t head
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;
  bp_entry_t      mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update: reset and clear both empty the queue.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRST || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
      if (pop  && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage written at the tail.
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; the pointers alone define which slots are valid.
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/branch_resolve_tracker.sv
// Tracks fetch-stage predictions against execute-stage resolution: detects
// mispredicts, drives flush/redirect, and serialises predictor training writes.
module branch_resolve_tracker
  import bp_tracker_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              fetch_pred_taken,
  input  logic [ADDR_W-1:0] fetch_pred_target,
  output logic              fetch_ready,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  input  logic [ADDR_W-1:0] resolve_target,
  output logic              resolve_ready,
  input  logic              flush_in,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_pc,
  output logic              upd_taken,
  output logic [ADDR_W-1:0] upd_target,
  input  logic              upd_ready,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  // The entry structs are sized by the package; the port width must match.
  if (ADDR_W != BP_ADDR_W) begin : g_addr_w_check
    $error("branch_resolve_tracker: ADDR_W must equal BP_ADDR_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("branch_resolve_tracker: DEPTH must be a power of two >= 2");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  upd_state_t upd_state_q;
  upd_state_t upd_state_d;
  bp_update_t upd_buf_q;
  bp_update_t upd_load;
  bp_entry_t  fetch_entry;
  bp_entry_t  head;
  logic       q_full;
  logic       q_empty;
  logic       push_fire;
  logic       pop_fire;
  logic       pop_acc;
  logic       head_wrong;
  logic       mispred_now;
  logic       q_clear;

  assign fetch_entry = '{pc: fetch_pc, pred_taken: fetch_pred_taken,
                         pred_target: fetch_pred_target};

  assign fetch_ready   = !q_full;
  assign resolve_ready = !q_empty && (upd_state_q == UPD_IDLE);

  assign push_fire = fetch_valid && fetch_ready;
  assign pop_fire  = resolve_valid && resolve_ready;
  // An external flush discards a pop in the same cycle entirely.
  assign pop_acc   = pop_fire && !flush_in;

  // Not-taken outcomes ignore the target.
  assign head_wrong  = (head.pred_taken != resolve_taken) ||
                       (resolve_taken && (head.pred_target != resolve_target));
  assign mispred_now = pop_acc && head_wrong;

  // Younger entries are wrong-path on a mispredict, so it clears like a flush.
  assign q_clear = flush_in || mispred_now;

  // Not-taken branches train with the fall-through address as target.
  assign upd_load = '{pc: head.pc, taken: resolve_taken,
                      target: resolve_taken ? resolve_target : head.pc + PC_INCR};

  bp_track_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .push       (push_fire && !q_clear),
    .push_entry (fetch_entry),
    .pop        (pop_acc),
    .clear      (q_clear),
    .full       (q_full),
    .empty      (q_empty),
    .head       (head)
  );

  // Update FSM state register.
  always_ff @(posedge CLK) begin
    if (!nRST) upd_state_q <= UPD_IDLE;
    else       upd_state_q <= upd_state_d;
  end

  // Update FSM next-state: one training write outstanding at a time.
  always_comb begin
    // NOTE: default assigned first so no path leaves upd_state_d unassigned (no latch).
    upd_state_d = upd_state_q;
    case (upd_state_q)
      UPD_IDLE:     if (pop_acc)   upd_state_d = UPD_WAIT_ACK;
      UPD_WAIT_ACK: if (upd_ready) upd_state_d = UPD_IDLE;
      default:                     upd_state_d = UPD_IDLE;
    endcase
  end

  // Update buffer: loaded on a pop, held stable while the write waits.
  always_ff @(posedge CLK) begin
    if (!nRST)                                upd_buf_q <= '0;
    else if (upd_state_q == UPD_IDLE && pop_acc) upd_buf_q <= upd_load;
  end

  assign upd_valid  = (upd_state_q == UPD_WAIT_ACK);
  assign upd_pc     = upd_buf_q.pc;
  assign upd_taken  = upd_buf_q.taken;
  assign upd_target = upd_buf_q.target;

  // One-cycle mispredict pulse; redirect_pc keeps its last value otherwise.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mispred_now;
      if (mispred_now) redirect_pc <= upd_load.target;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop_acc && branch_count != CNT_MAX)
        branch_count <= branch_count + CNT_ONE;
      if (mispred_now && mispredict_count != CNT_MAX)
        mispredict_count <= mispredict_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed bench for branch_resolve_tracker. Counters are built narrow so
// the all-ones saturation boundary is reachable in a short run.
module tb_branch_resolve_tracker;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              CLK;
  logic              nRST;
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_pred_taken;
  logic [ADDR_W-1:0] fetch_pred_target;
  logic              fetch_ready;
  logic              resolve_valid;
  logic              resolve_taken;
  logic [ADDR_W-1:0] resolve_target;
  logic              resolve_ready;
  logic              flush_in;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_ready;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolve_tracker #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .fetch_pred_taken  (fetch_pred_taken),
    .fetch_pred_target (fetch_pred_target),
    .fetch_ready       (fetch_ready),
    .resolve_valid     (resolve_valid),
    .resolve_taken     (resolve_taken),
    .resolve_target    (resolve_target),
    .resolve_ready     (resolve_ready),
    .flush_in          (flush_in),
    .mispredict        (mispredict),
    .redirect_pc       (redirect_pc),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .upd_ready         (upd_ready),
    .branch_count      (branch_count),
    .mispredict_count  (mispredict_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [ADDR_W-1:0] pc,
                           input logic t, input logic [ADDR_W-1:0] tgt);
    fetch_valid       = v;
    fetch_pc          = pc;
    fetch_pred_taken  = t;
    fetch_pred_target = tgt;
  endtask

  task automatic set_resolve(input logic v, input logic t, input logic [ADDR_W-1:0] tgt);
    resolve_valid  = v;
    resolve_taken  = t;
    resolve_target = tgt;
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_pc;
    int                n_upd;
    bit                done;

    nRST = 1'b0;
    flush_in = 1'b0;
    upd_ready = 1'b0;
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b0, 1'b0, '0);
    tick();
    tick();
    nRST = 1'b1;
    tick();

    // Reset / idle state
    check("rst_fetch_ready", fetch_ready, 1);
    check("rst_resolve_ready", resolve_ready, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_mispredict", mispredict, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_upd_pc", upd_pc, 0);
    check("rst_branch_cnt", branch_count, 0);
    check("rst_mispred_cnt", mispredict_count, 0);

    // Fill the queue, then offer a fifth fetch that must be ignored
    for (int i = 1; i <= 4; i++) begin
      set_fetch(1'b1, ADDR_W'(i * 32'h100), 1'b0, '0);
      tick();
    end
    check("full_fetch_ready", fetch_ready, 0);
    set_fetch(1'b1, 32'h500, 1'b0, '0);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    check("full_hold_ready", fetch_ready, 0);

    // Drain with correct not-taken resolutions, acking every write
    upd_ready = 1'b1;
    set_resolve(1'b1, 1'b0, 32'hDEAD_BEEF);
    exp_pc = 32'h100;
    n_upd = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (upd_valid) begin
        check("drain_upd_pc", upd_pc, exp_pc);
        check("drain_upd_tgt", upd_target, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'h100;
        n_upd++;
      end
      if (mispredict) check("drain_no_mispred", mispredict, 0);
      if (branch_count == CNT_W'(4)) done = 1'b1;
    end
    set_resolve(1'b0, 1'b0, '0);
    tick();
    check("drain_n_updates", n_upd, 4);
    check("drain_branch_cnt", branch_count, 4);
    check("drain_mispred_cnt", mispredict_count, 0);
    check("drain_empty", resolve_ready, 0);
    check("drain_fetch_ready", fetch_ready, 1);

    // Not-taken prediction resolved taken: flush, redirect, younger entry dropped
    upd_ready = 1'b0;
    set_fetch(1'b1, 32'h100, 1'b0, '0);
    tick();
    set_fetch(1'b1, 32'h200, 1'b0, '0);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b1, 1'b1, 32'h800);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    check("mp1_pulse", mispredict, 1);
    check("mp1_redirect", redirect_pc, 32'h800);
    check("mp1_mispred_cnt", mispredict_count, 1);
    check("mp1_branch_cnt", branch_count, 5);
    check("mp1_upd_valid", upd_valid, 1);
    check("mp1_upd_pc", upd_pc, 32'h100);
    check("mp1_upd_taken", upd_taken, 1);
    check("mp1_upd_target", upd_target, 32'h800);
    check("mp1_fetch_ready", fetch_ready, 1);
    tick();
    check("mp1_pulse_end", mispredict, 0);
    upd_ready = 1'b1;
    tick();
    check("mp1_acked", upd_valid, 0);
    check("mp1_queue_empty", resolve_ready, 0);

    // Taken with wrong target
    set_fetch(1'b1, 32'h300, 1'b1, 32'h500);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b1, 1'b1, 32'h600);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    check("mp2_pulse", mispredict, 1);
    check("mp2_redirect", redirect_pc, 32'h600);
    tick();

    // Predicted taken, resolved not-taken: redirect to pc+4
    set_fetch(1'b1, 32'h1FC, 1'b1, 32'h300);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b1, 1'b0, 32'hDEAD);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    check("mp3_pulse", mispredict, 1);
    check("mp3_redirect", redirect_pc, 32'h200);
    check("mp3_upd_taken", upd_taken, 0);
    check("mp3_upd_target", upd_target, 32'h200);
    check("mp3_mispred_cnt", mispredict_count, 3);
    tick();

    // Correct taken prediction with a simultaneous push
    set_fetch(1'b1, 32'h40, 1'b1, 32'h80);
    tick();
    set_fetch(1'b1, 32'h44, 1'b0, '0);
    set_resolve(1'b1, 1'b1, 32'h80);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b0, 1'b0, '0);
    check("ok_no_pulse", mispredict, 0);
    check("ok_upd_target", upd_target, 32'h80);
    check("ok_mispred_cnt", mispredict_count, 3);
    tick();
    check("ok_push_kept", resolve_ready, 1);
    set_resolve(1'b1, 1'b0, '0);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    check("ok2_no_pulse", mispredict, 0);
    check("ok2_upd_pc", upd_pc, 32'h44);
    check("ok2_upd_target", upd_target, 32'h48);
    check("ok2_branch_cnt", branch_count, 9);
    tick();

    // Stalled acknowledge: buffer holds, next resolve waits
    upd_ready = 1'b0;
    set_fetch(1'b1, 32'h600, 1'b0, '0);
    tick();
    set_fetch(1'b1, 32'h700, 1'b0, '0);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b1, 1'b0, '0);
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_upd_valid", upd_valid, 1);
      check("stall_upd_pc", upd_pc, 32'h600);
      check("stall_resolve_ready", resolve_ready, 0);
      check("stall_branch_cnt", branch_count, 10);
    end
    upd_ready = 1'b1;
    tick();
    check("stall_acked", upd_valid, 0);
    check("stall_not_consumed", branch_count, 10);
    check("stall_ready_back", resolve_ready, 1);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    check("stall_second_pop", branch_count, 11);
    check("stall_second_pc", upd_pc, 32'h700);
    tick();

    // External flush with 3 entries, a pending update and a simultaneous push
    upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, ADDR_W'(32'h900 + i * 32'h100), 1'b0, '0);
      tick();
    end
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b1, 1'b0, '0);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    flush_in = 1'b1;
    set_fetch(1'b1, 32'hD00, 1'b0, '0);
    tick();
    flush_in = 1'b0;
    set_fetch(1'b0, '0, 1'b0, '0);
    check("fl_no_pulse", mispredict, 0);
    check("fl_upd_valid", upd_valid, 1);
    check("fl_upd_pc", upd_pc, 32'h900);
    check("fl_fetch_ready", fetch_ready, 1);
    upd_ready = 1'b1;
    tick();
    check("fl_queue_empty", resolve_ready, 0);
    check("fl_branch_cnt", branch_count, 12);
    check("fl_mispred_cnt", mispredict_count, 3);

    // Saturation: repeated mispredicts until the counter reaches all-ones
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      set_fetch(1'b1, 32'h10, 1'b0, '0);
      tick();
      set_fetch(1'b0, '0, 1'b0, '0);
      set_resolve(1'b1, 1'b1, 32'h20);
      tick();
      set_resolve(1'b0, 1'b0, '0);
      if (mispredict_count == CNT_MAX) done = 1'b1;
    end
    check("sat_reached", mispredict_count, CNT_MAX);
    set_fetch(1'b1, 32'h10, 1'b0, '0);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b1, 1'b1, 32'h20);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    check("sat_pulse", mispredict, 1);
    check("sat_mispred_hold", mispredict_count, CNT_MAX);
    check("sat_branch_hold", branch_count, CNT_MAX);
    tick();

    // Reset mid-operation drops queued entries and the pending update
    upd_ready = 1'b0;
    set_fetch(1'b1, 32'hA0, 1'b0, '0);
    tick();
    set_fetch(1'b1, 32'hB0, 1'b0, '0);
    tick();
    set_fetch(1'b0, '0, 1'b0, '0);
    set_resolve(1'b1, 1'b0, '0);
    tick();
    set_resolve(1'b0, 1'b0, '0);
    check("mid_upd_pending", upd_valid, 1);
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    check("mid_rst_fetch_ready", fetch_ready, 1);
    check("mid_rst_resolve_ready", resolve_ready, 0);
    check("mid_rst_upd_valid", upd_valid, 0);
    check("mid_rst_upd_pc", upd_pc, 0);
    check("mid_rst_redirect", redirect_pc, 0);
    check("mid_rst_branch_cnt", branch_count, 0);
    check("mid_rst_mispred_cnt", mispredict_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
